// File: rtl/gpio_pad_ctrl.sv
// Core-side controller for a bank of bidirectional IO cells: direction/output
// drive, synchronised and debounced input sampling, edge capture and interrupt.
module gpio_pad_ctrl #(
  parameter int N_PINS          = 8,
  parameter int CONF_WIDTH      = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                         clk_in,
  input  logic                         reset_int,
  input  logic                         reg_we,
  input  logic                         reg_re,
  input  logic [2:0]                   reg_addr,
  input  logic [N_PINS-1:0]            reg_wdata,
  output logic [N_PINS-1:0]            reg_rdata,
  output logic                         reg_rvalid,
  output logic [N_PINS*CONF_WIDTH-1:0] io_cell_cfg,
  output logic [N_PINS-1:0]            from_core,
  input  logic [N_PINS-1:0]            to_core,
  output logic                         irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_DIR     = 3'd0;
  localparam logic [2:0] ADDR_OUT     = 3'd1;
  localparam logic [2:0] ADDR_IN      = 3'd2;
  localparam logic [2:0] ADDR_RISE_EN = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN = 3'd4;
  localparam logic [2:0] ADDR_STATUS  = 3'd5;

  logic [N_PINS-1:0] dir_q, dir_d;
  logic [N_PINS-1:0] out_q, out_d;
  logic [N_PINS-1:0] rise_en_q, rise_en_d;
  logic [N_PINS-1:0] fall_en_q, fall_en_d;
  logic [N_PINS-1:0] status_q, status_d;
  logic [N_PINS-1:0] in_q, in_d;
  logic [N_PINS-1:0] sync1_q, sync2_q;
  logic [CNT_W-1:0]  cnt_q [N_PINS];
  logic [CNT_W-1:0]  cnt_d [N_PINS];
  logic [N_PINS-1:0] rdata_q, rdata_d;
  logic              rvalid_q;
  logic              irq_q;
  logic [N_PINS-1:0] w1c;
  logic [N_PINS-1:0] rise_evt, fall_evt;

  always_comb begin
    dir_d     = dir_q;
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (reg_we) begin
      unique case (reg_addr)
        ADDR_DIR:     dir_d     = reg_wdata;
        ADDR_OUT:     out_d     = reg_wdata;
        ADDR_RISE_EN: rise_en_d = reg_wdata;
        ADDR_FALL_EN: fall_en_d = reg_wdata;
        ADDR_STATUS:  w1c       = reg_wdata;
        default:      ;
      endcase
    end
  end

  // A pin's filtered value moves only after sync2 has disagreed with it for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    in_d = in_q;
    for (int i = 0; i < N_PINS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != in_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          in_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Event set takes priority over a same-cycle W1C clear.
  always_comb begin
    rise_evt = in_d & ~in_q & rise_en_q;
    fall_evt = ~in_d & in_q & fall_en_q;
    status_d = (status_q & ~w1c) | rise_evt | fall_evt;
  end

  always_comb begin
    rdata_d = '0;
    if (reg_re) begin
      unique case (reg_addr)
        ADDR_DIR:     rdata_d = dir_q;
        ADDR_OUT:     rdata_d = out_q;
        ADDR_IN:      rdata_d = in_q;
        ADDR_RISE_EN: rdata_d = rise_en_q;
        ADDR_FALL_EN: rdata_d = fall_en_q;
        ADDR_STATUS:  rdata_d = status_q;
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      dir_q     <= '1;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      in_q      <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      for (int i = 0; i < N_PINS; i++) cnt_q[i] <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      out_q     <= out_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      in_q      <= in_d;
      sync1_q   <= to_core;
      sync2_q   <= sync1_q;
      for (int i = 0; i < N_PINS; i++) cnt_q[i] <= cnt_d[i];
      rdata_q   <= rdata_d;
      rvalid_q  <= reg_re;
      irq_q     <= |status_q;
    end
  end

  always_comb begin
    io_cell_cfg = '0;
    for (int i = 0; i < N_PINS; i++) begin
      io_cell_cfg[i*CONF_WIDTH] = dir_q[i];
    end
  end

  assign from_core  = out_q;
  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl: read results go through an expectation
// queue that a negedge monitor drains whenever reg_rvalid is seen.
module tb_gpio_pad_ctrl;
  localparam int N  = 8;
  localparam int CW = 3;
  localparam int DB = 4;

  logic            clk_in = 1'b0;
  logic            reset_int = 1'b0;
  logic            reg_we = 1'b0;
  logic            reg_re = 1'b0;
  logic [2:0]      reg_addr = '0;
  logic [N-1:0]    reg_wdata = '0;
  logic [N-1:0]    to_core = '0;
  logic [N-1:0]    reg_rdata;
  logic            reg_rvalid;
  logic [N*CW-1:0] io_cell_cfg;
  logic [N-1:0]    from_core;
  logic            irq;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_q [$];
  string        tag_q [$];
  logic [N-1:0] mon_exp;
  string        mon_tag;

  gpio_pad_ctrl #(.N_PINS(N), .CONF_WIDTH(CW), .DEBOUNCE_CYCLES(DB)) dut (
    .clk_in(clk_in), .reset_int(reset_int), .reg_we(reg_we), .reg_re(reg_re),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .reg_rvalid(reg_rvalid), .io_cell_cfg(io_cell_cfg), .from_core(from_core),
    .to_core(to_core), .irq(irq)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (reg_rvalid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL rvalid_unexpected observed=%0h expected=none", reg_rdata);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        checks++;
        assert (reg_rdata === mon_exp) else begin
          errors++;
          $error("FAIL %s observed=%0h expected=%0h", mon_tag, reg_rdata, mon_exp);
        end
      end
    end
  end

  function automatic logic [N*CW-1:0] cfg_of(input logic [N-1:0] dir);
    logic [N*CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c[i*CW] = dir[i];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 6 && exp_q.size() != 0; i++) tick();
    chk("read_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tag_q.delete();
  endtask

  task automatic do_write(input logic [2:0] a, input logic [N-1:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, input logic [N-1:0] exp, input string tag);
    exp_q.push_back(exp); tag_q.push_back(tag);
    reg_re = 1'b1; reg_addr = a;
    tick();
    reg_re = 1'b0;
    drain();
  endtask

  // Back-to-back reads; iteration c returns the register as it stood before edge c.
  task automatic read_stream(input logic [2:0] a, input int n, input int thr,
                             input logic [N-1:0] hi, input string tag);
    for (int c = 0; c < n; c++) begin
      exp_q.push_back((c >= thr) ? hi : '0);
      tag_q.push_back($sformatf("%s_c%0d", tag, c));
      reg_re = 1'b1; reg_addr = a;
      tick();
    end
    reg_re = 1'b0;
    drain();
  endtask

  initial begin
    repeat (3) tick();
    reset_int = 1'b1;
    tick();

    chk("rst_from_core", 32'(from_core), 32'h00);
    chk("rst_cfg", 32'(io_cell_cfg), 32'(cfg_of(8'hFF)));
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rvalid", 32'(reg_rvalid), 32'd0);
    do_read(3'd0, 8'hFF, "rst_dir");
    do_read(3'd1, 8'h00, "rst_out");
    do_read(3'd2, 8'h00, "rst_in");
    do_read(3'd3, 8'h00, "rst_rise_en");
    do_read(3'd4, 8'h00, "rst_fall_en");
    do_read(3'd5, 8'h00, "rst_status");
    chk("rdata_idle", 32'(reg_rdata), 32'd0);

    do_write(3'd0, 8'h0F);
    chk("dir_cfg", 32'(io_cell_cfg), 32'(cfg_of(8'h0F)));
    do_write(3'd1, 8'hA5);
    chk("out_drive", 32'(from_core), 32'hA5);
    do_read(3'd0, 8'h0F, "dir_rb");

    exp_q.push_back(8'hA5); tag_q.push_back("rd_wr_collide_old");
    reg_we = 1'b1; reg_re = 1'b1; reg_addr = 3'd1; reg_wdata = 8'h3C;
    tick();
    reg_we = 1'b0; reg_re = 1'b0;
    drain();
    chk("out_after_collide", 32'(from_core), 32'h3C);

    do_write(3'd2, 8'hFF);
    do_write(3'd6, 8'hFF);
    do_read(3'd2, 8'h00, "in_write_ignored");
    do_read(3'd6, 8'h00, "addr6_zero");
    do_read(3'd7, 8'h00, "addr7_zero");
    do_write(3'd0, 8'hFF);

    to_core[2] = 1'b1;
    read_stream(3'd2, 9, 6, 8'h04, "deb_pin2");

    do_write(3'd3, 8'h08);
    to_core[3] = 1'b1;
    repeat (3) tick();
    to_core[3] = 1'b0;
    repeat (8) tick();
    do_read(3'd2, 8'h04, "glitch_in");
    do_read(3'd5, 8'h00, "glitch_status");

    do_write(3'd3, 8'h01);
    do_write(3'd4, 8'h02);
    to_core[1] = 1'b1;
    repeat (8) tick();
    do_read(3'd5, 8'h00, "rise_not_enabled");
    to_core[0] = 1'b1;
    to_core[1] = 1'b0;
    repeat (8) tick();
    do_read(3'd5, 8'h03, "edge_status");
    chk("edge_irq", 32'(irq), 32'd1);
    do_write(3'd5, 8'h01);
    do_read(3'd5, 8'h02, "w1c_bit0");
    chk("irq_still_set", 32'(irq), 32'd1);
    do_write(3'd5, 8'h02);
    chk("irq_lag", 32'(irq), 32'd1);
    tick();
    chk("irq_cleared", 32'(irq), 32'd0);

    to_core[0] = 1'b0;
    repeat (8) tick();
    do_read(3'd5, 8'h00, "fall_pin0_silent");
    to_core[0] = 1'b1;
    repeat (5) tick();
    do_write(3'd5, 8'h01);
    do_read(3'd5, 8'h01, "set_beats_clear");
    chk("collide_irq", 32'(irq), 32'd1);

    to_core[4] = 1'b1;
    repeat (2) tick();
    reset_int = 1'b0;
    #2;
    chk("async_rst_irq", 32'(irq), 32'd0);
    chk("async_rst_from_core", 32'(from_core), 32'h00);
    chk("async_rst_cfg", 32'(io_cell_cfg), 32'(cfg_of(8'hFF)));
    tick();
    reset_int = 1'b1;
    read_stream(3'd2, 10, 6, to_core, "rst_deb");
    do_read(3'd5, 8'h00, "rst_no_status");
    do_read(3'd0, 8'hFF, "rst_mid_dir");
    chk("rst_mid_irq", 32'(irq), 32'd0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
